instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the PC, drives word addresses to the instruction memory and collects the returned instruction words.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles stalls (backpressure), branch/jump redirects (flush) and halt.
- Sits between InstructionMemory and the decode stage of the CPU.

Parameters:
- bus, 32, width of address, PC and instruction data.
- resetVector, 0, PC loaded on reset.
- addrStep, 1, PC increment per instruction: 1 for the word-indexed memory, 4 for byte addressing.
- fifoDepth, 4, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_address  out  bus  address driven to instruction memory.
- mem_req  out  1  a fetch is issued this cycle.
- mem_data  in  bus  instruction word; valid exactly one cycle after the cycle mem_req=1.
- instr  out  bus  instruction at FIFO head.
- instr_pc  out  bus  PC of instruction at FIFO head.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head when instr_valid&&instr_ready.
- redirect_valid  in  1  flush and restart at redirect_target.
- redirect_target  in  bus  new PC.
- halt  in  1  stop issuing new fetches while high.
- busy  out  1  a fetch is in flight or FIFO not empty.

Behaviour:
- Reset (synchronous, active-high): fetch_pc=resetVector, state=BOOT, FIFO empty, in-flight flag clear. Outputs: mem_address=resetVector, mem_req=0, instr_valid=0, instr=0, instr_pc=0, busy=0. Reset asserted mid-operation discards all buffered and in-flight data; the next cycle behaves as after power-up.
- States:
  - BOOT: one cycle, no issue; goes to RUN, or HALTED if halt=1.
  - RUN: issues fetches.
  - HALTED: no issue. Returns to RUN on the first cycle halt=0; redirect is still accepted here.
- Issue rule in RUN: mem_req=1 when halt=0, redirect_valid=0 and (fifo_count + inflight) < fifoDepth. Then mem_address=fetch_pc, and fetch_pc advances by addrStep at the edge.
- PC arithmetic is modulo 2^bus; wrap-around from the top address is legal and continues fetching.
- Response: an issue in cycle T sets inflight with tag pc=fetch_pc. At the edge ending cycle T+1, mem_data and its pc are written to the FIFO tail unless killed.
  - instr_valid rises at T+2.
  - Issue-to-output latency is 2 cycles.
  - Back-to-back issue gives 1 instr/cycle sustained with instr_ready=1.
- Handshake: the head is popped at the edge when instr_valid&&instr_ready. instr/instr_pc are held stable while instr_valid=1 and not popped. Push and pop in the same cycle keep the count unchanged. The FIFO never overflows because of the credit rule.
- Redirect (highest priority, any state except BOOT):
  - In the redirect cycle, instr_valid is forced 0 combinationally, so no handshake occurs, and mem_req=0.
  - At the edge: FIFO flushed, any in-flight response killed (its mem_data next cycle is discarded), fetch_pc=redirect_target.
  - First fetch of the target is issued the following cycle. Its instruction appears at instr 3 cycles after the redirect cycle.
  - Redirect during BOOT is applied at the end of BOOT identically.
- Halt: blocks new issues only; an in-flight response still lands, and buffered entries still drain. busy falls once the FIFO is empty and nothing is in flight.
- Simultaneous events:
  - redirect beats halt (PC updated, still halted).
  - redirect beats push and pop.
  - reset beats everything.

Test Plan:
- Reset then halt=0, instr_ready=1, memory word[i]=i+0x100 → mem_address 0,1,2,… one per cycle from cycle 1; instr_pc=0 / instr=0x100 valid at cycle 3, then 1/0x101, 2/0x102 on consecutive cycles.
- instr_ready=0 after start → exactly fifoDepth=4 entries buffered (PCs 0..3), mem_req drops to 0, instr holds 0x100; raising ready drains 0x100..0x103 in order with no gaps or duplicates.
- redirect_valid=1, target=0x40 while entries buffered and a fetch is in flight → instr_valid=0 that cycle and next two; mem_address=0x40 next cycle; first output instr_pc=0x40, instr=word[0x40]; no stale PCs ever appear.
- halt=1 mid-stream → no further mem_req, in-flight word still delivered, busy falls after drain; halt=0 → fetch resumes at the next sequential PC.
- resetVector=32'hFFFF_FFFE, addrStep=1 → PCs FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001 fetched in order.
- Reset asserted for one cycle mid-stream with full FIFO → next cycle instr_valid=0, mem_req=0, busy=0; fetching restarts from resetVector.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory and decode-side signal bundle of the fetch unit
interface instruction_fetch_unit_if #(
  parameter int unsigned bus = 32
);
  logic [bus-1:0] mem_address;
  logic           mem_req;
  logic [bus-1:0] mem_data;
  logic [bus-1:0] instr;
  logic [bus-1:0] instr_pc;
  logic           instr_valid;
  logic           instr_ready;
  logic           redirect_valid;
  logic [bus-1:0] redirect_target;
  logic           halt;
  logic           busy;

  // Fetch unit side: drives the memory request and the decode stream.
  modport master (
    output mem_address, mem_req, instr, instr_pc, instr_valid, busy,
    input  mem_data, instr_ready, redirect_valid, redirect_target, halt
  );

  // Environment side: instruction memory, decode stage and control.
  modport slave (
    input  mem_address, mem_req, instr, instr_pc, instr_valid, busy,
    output mem_data, instr_ready, redirect_valid, redirect_target, halt
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, credit-limited fetch issue and instruction buffer toward decode
module instruction_fetch_unit #(
  parameter int unsigned    bus         = 32,
  parameter logic [bus-1:0] resetVector = '0,
  parameter int unsigned    addrStep    = 1,
  parameter int unsigned    fifoDepth   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master ifu
);
  localparam int unsigned    PtrW     = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int unsigned    CntW     = PtrW + 1;
  localparam int unsigned    OccW     = CntW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(fifoDepth);
  localparam logic [bus-1:0] StepPc   = bus'(addrStep);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [bus-1:0]  fetch_pc_q, fetch_pc_d;
  logic            inflight_q;
  logic [bus-1:0]  inflight_pc_q;
  logic [bus-1:0]  fifo_instr_q [fifoDepth];
  logic [bus-1:0]  fifo_pc_q    [fifoDepth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic [OccW-1:0] occupancy;
  logic            head_valid;
  logic            redirect;
  logic            issue;
  logic            push;
  logic            pop;

  // Issue credit counts in-flight words so the buffer can never overflow; redirect suppresses issue, push and pop.
  always_comb begin
    redirect   = ifu.redirect_valid;
    head_valid = (count_q != '0);
    occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    issue      = (state_q == RUN) && !ifu.halt && !redirect && (occupancy < DepthOcc);
    push       = inflight_q && !redirect;
    pop        = head_valid && !redirect && ifu.instr_ready;
  end

  // Next state and next PC; a redirect overrides sequential advance in every state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      BOOT:    state_d = ifu.halt ? HALTED : RUN;
      RUN:     if (ifu.halt) state_d = HALTED;
      HALTED:  if (!ifu.halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      fetch_pc_d = ifu.redirect_target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + StepPc;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, in-flight tag and buffer pointers; a redirect flushes the buffer and kills the pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= resetVector;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Buffer storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= ifu.mem_data;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign ifu.mem_address = fetch_pc_q;
  assign ifu.mem_req     = issue;
  assign ifu.instr_valid = head_valid && !redirect;
  assign ifu.instr       = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign ifu.instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign ifu.busy        = inflight_q || head_valid;
endmodule
